// File: rtl/simple_rtl_unit.sv
// simple_rtl_unit: clock-aligned sampler of the serial input a.
// S0 holds the last sampled value, EDGE flags that S0 just changed, and
// CNT counts those changes modulo 2^CNT_W. Every output is a flop output.
`timescale 1ns/1ps

module simple_rtl_unit #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             a,
  output logic             S0,
  output logic             EDGE,
  output logic [CNT_W-1:0] CNT
);

  logic             s0_q;
  logic             s0_d;
  logic             edge_q;
  logic             edge_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             changed;

  // Next state: a change is the incoming sample differing from the held one
  always_comb begin
    changed = (a != s0_q);
    s0_d    = a;
    edge_d  = changed;
    cnt_d   = changed ? (cnt_q + CNT_W'(1)) : cnt_q;
  end

  // State registers; reset clears everything immediately, without a clock
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s0_q   <= 1'b0;
      edge_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s0_q   <= s0_d;
      edge_q <= edge_d;
      cnt_q  <= cnt_d;
    end
  end

  assign S0   = s0_q;
  assign EDGE = edge_q;
  assign CNT  = cnt_q;

endmodule

// File: tb/tb_simple_rtl_unit.sv
// tb_simple_rtl_unit: directed bench for simple_rtl_unit.
// Two instances share stimulus: the default 8-bit counter and a 2-bit
// counter used to observe wrap-around.
`timescale 1ns/1ps

module tb_simple_rtl_unit;

  logic       CLK;
  logic       RST;
  logic       a;
  logic       S0;
  logic       EDGE;
  logic [7:0] CNT;
  logic       S0w;
  logic       EDGEw;
  logic [1:0] CNTw;

  int testsRun;
  int testsFailed;

  simple_rtl_unit #(.CNT_W(8)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .a    (a),
    .S0   (S0),
    .EDGE (EDGE),
    .CNT  (CNT)
  );

  simple_rtl_unit #(.CNT_W(2)) dutWrap (
    .CLK  (CLK),
    .RST  (RST),
    .a    (a),
    .S0   (S0w),
    .EDGE (EDGEw),
    .CNT  (CNTw)
  );

  // 1 ns clock, rising edges at 0.5, 1.5, 2.5 ...
  initial begin
    CLK = 1'b0;
    forever #0.5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag, input int expS0, input int expEdge,
                          input int expCnt, input int expCntWrap);
    checkOutput({tag, ".S0"},    int'(S0),    expS0);
    checkOutput({tag, ".EDGE"},  int'(EDGE),  expEdge);
    checkOutput({tag, ".CNT"},   int'(CNT),   expCnt);
    checkOutput({tag, ".CNTw"},  int'(CNTw),  expCntWrap);
    checkOutput({tag, ".S0w"},   int'(S0w),   expS0);
    checkOutput({tag, ".EDGEw"}, int'(EDGEw), expEdge);
  endtask

  task automatic applyStimulus();
    // Reset held with a = 1 and the clock running
    a   = 1'b1;
    RST = 1'b1;
    #0.2;
    checkAll("rst_initial", 0, 0, 0, 0);
    repeat (3) begin
      @(posedge CLK);
      #0.5;
      checkAll("rst_hold", 0, 0, 0, 0);
    end

    // Release at a falling edge with a = 0, then ten quiet cycles
    a   = 1'b0;
    RST = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK);
      #0.5;
      checkAll("steady0", 0, 0, 0, 0);
    end

    // Toggle a 0.4 ns after each rising edge; wrap counter reads 1,2,3,0,1 on edges 2..6
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK);
      #0.4 a = ~a;
      #0.1;
      checkAll("toggle", (k - 1) % 2, int'(k >= 2), k - 1, (k - 1) % 4);
    end

    // Asynchronous reset from a busy state (S0 = 1, CNT = 9)
    RST = 1'b1;
    #0.1;
    checkAll("rst_async", 0, 0, 0, 0);
    a = 1'b1;
    @(posedge CLK);
    #0.5;
    checkAll("rst_edge_ignored", 0, 0, 0, 0);
    a   = 1'b0;
    RST = 1'b0;

    // Single 0->1 change sampled at edge 5
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK);
      if (k == 4) begin
        #0.4 a = 1'b1;
        #0.1;
      end else begin
        #0.5;
      end
      checkAll("single", int'(k >= 5), int'(k == 5), int'(k >= 5), int'(k >= 5));
    end

    // Build up CNT = 3 with S0 = 1
    a = 1'b0;
    @(posedge CLK);
    #0.5;
    checkAll("build2", 0, 1, 2, 2);
    a = 1'b1;
    @(posedge CLK);
    #0.5;
    checkAll("build3", 1, 1, 3, 3);

    // 0.3 ns reset pulse between edges, then a = 1 at the next edge counts
    @(posedge CLK);
    #0.1 RST = 1'b1;
    #0.1;
    checkAll("midrst", 0, 0, 0, 0);
    #0.2 RST = 1'b0;
    #0.3;
    checkAll("midrst_release", 0, 0, 0, 0);
    @(posedge CLK);
    #0.5;
    checkAll("midrst_first", 1, 1, 1, 1);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
